// File: rtl/apb_master_if.sv
// Command, response and APB signal bundle for apb_master.
// The master modport is the requester's view; slave is the environment's view.
interface apb_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 8
) ();
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              rsp_timeout;

  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
    input  prdata, pready, pslverr,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    output psel, penable, pwrite, paddr, pwdata
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready,
    output prdata, pready, pslverr,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    input  psel, penable, pwrite, paddr, pwdata
  );
endinterface

// File: rtl/apb_master.sv
// Single-outstanding APB requester: valid/ready command in, APB SETUP/ACCESS
// transfer out, valid/ready response back, with a wait-state timeout.
module apb_master #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 16
) (
  input logic          pclk,
  input logic          prst,
  apb_master_if.master bus
);
  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_wait;
  logic              r_psel;
  logic              r_penable;
  logic              r_pwrite;
  logic [ADDR_W-1:0] r_paddr;
  logic [DATA_W-1:0] r_pwdata;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic              r_rsp_err;
  logic              r_rsp_timeout;
  logic              w_req_ready;
  logic              w_accept;

  assign w_req_ready = (r_state == IDLE) && !prst;
  assign w_accept    = bus.req_valid && w_req_ready;

  assign bus.req_ready   = w_req_ready;
  assign bus.psel        = r_psel;
  assign bus.penable     = r_penable;
  assign bus.pwrite      = r_pwrite;
  assign bus.paddr       = r_paddr;
  assign bus.pwdata      = r_pwdata;
  assign bus.rsp_valid   = r_rsp_valid;
  assign bus.rsp_rdata   = r_rsp_rdata;
  assign bus.rsp_err     = r_rsp_err;
  assign bus.rsp_timeout = r_rsp_timeout;

  always_ff @(posedge pclk) begin
    if (prst) begin
      r_state       <= IDLE;
      r_wait        <= '0;
      r_psel        <= 1'b0;
      r_penable     <= 1'b0;
      r_pwrite      <= 1'b0;
      r_paddr       <= '0;
      r_pwdata      <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= '0;
      r_rsp_err     <= 1'b0;
      r_rsp_timeout <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_pwrite  <= bus.req_write;
            r_paddr   <= bus.req_addr;
            r_pwdata  <= bus.req_write ? bus.req_wdata : '0;
            r_psel    <= 1'b1;
            r_penable <= 1'b0;
            r_state   <= SETUP;
          end
        end
        SETUP: begin
          r_penable <= 1'b1;
          r_wait    <= '0;
          r_state   <= ACCESS;
        end
        ACCESS: begin
          // pready on the final permitted edge still completes normally
          if (bus.pready) begin
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_rsp_valid   <= 1'b1;
            r_rsp_err     <= bus.pslverr;
            r_rsp_timeout <= 1'b0;
            r_rsp_rdata   <= (!r_pwrite && !bus.pslverr) ? bus.prdata : '0;
            r_state       <= RESP;
          end else if (r_wait == LAST_WAIT) begin
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_rsp_valid   <= 1'b1;
            r_rsp_err     <= 1'b1;
            r_rsp_timeout <= 1'b1;
            r_rsp_rdata   <= '0;
            r_state       <= RESP;
          end else begin
            r_wait <= r_wait + 1'b1;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_apb_master.sv
// Randomized scoreboard bench for apb_master: a slave model answers each
// transfer per a planned wait count, and a monitor checks a cycle timeline.
module tb_apb_master;
  localparam int AW = 32;
  localparam int DW = 8;
  localparam int TO = 16;

  typedef struct {
    bit          write;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int          waits;
    bit          slverr;
    logic [DW-1:0] prdata;
  } txn_t;

  logic pclk = 1'b0;
  logic prst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   bp_len = -1;
  bit   busy = 1'b0;
  txn_t exp_q[$];
  txn_t plan_q[$];

  apb_master_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  apb_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .pclk(pclk),
    .prst(prst),
    .bus (bus)
  );

  always #5 pclk = ~pclk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference: a slave that holds pready low for 'waits' edges; the master
  // gives up after TO ACCESS cycles.
  function automatic int acc_cycles(input txn_t t);
    return (t.waits >= TO) ? TO : t.waits + 1;
  endfunction

  function automatic logic [DW+1:0] model_rsp(input txn_t t);
    logic [DW-1:0] rd;
    if (t.waits >= TO) return {{DW{1'b0}}, 1'b1, 1'b1};
    rd = (!t.write && !t.slverr) ? t.prdata : {DW{1'b0}};
    return {rd, t.slverr, 1'b0};
  endfunction

  // APB slave model
  initial begin
    txn_t cur;
    int   acnt = 0;
    bus.pready = 1'b0; bus.prdata = '0; bus.pslverr = 1'b0;
    forever begin
      @(posedge pclk); #1;
      if (prst || !(bus.psel && bus.penable)) begin
        acnt = 0;
        bus.pready  = 1'($urandom_range(0, 1));
        bus.prdata  = DW'($urandom);
        bus.pslverr = 1'($urandom_range(0, 1));
      end else begin
        if (acnt == 0) begin
          if (plan_q.size() == 0) begin
            errors++; checks++;
            $display("FAIL slave_plan: got ACCESS expected no transfer at %0t", $time);
            cur.waits = 0; cur.slverr = 0; cur.prdata = '0;
          end else cur = plan_q.pop_front();
        end
        if (acnt == cur.waits) begin
          bus.pready = 1'b1; bus.prdata = cur.prdata; bus.pslverr = cur.slverr;
        end else begin
          bus.pready = 1'b0; bus.prdata = DW'($urandom); bus.pslverr = 1'($urandom_range(0, 1));
        end
        acnt++;
      end
    end
  end

  // Response consumer with scripted or random back-pressure
  initial begin
    int hold = 0;
    bit seen = 1'b0;
    bus.rsp_ready = 1'b0;
    forever begin
      @(posedge pclk); #1;
      if (prst || !bus.rsp_valid) begin
        seen = 1'b0;
        bus.rsp_ready = 1'($urandom_range(0, 1));
      end else begin
        if (!seen) begin
          seen = 1'b1;
          hold = (bp_len >= 0) ? bp_len : int'($urandom_range(0, 3));
        end
        if (hold > 0) begin bus.rsp_ready = 1'b0; hold--; end
        else bus.rsp_ready = 1'b1;
      end
    end
  end

  // Monitor: timeline after accept is 1 SETUP, n ACCESS, then RESP until taken
  initial begin
    txn_t          cur;
    int            k = 0;
    int            n;
    logic [2:0]    expc;
    logic [DW-1:0] expw;
    forever begin
      @(negedge pclk);
      if (prst) busy = 1'b0;
      else begin
        chk("req_ready", 64'(bus.req_ready), 64'(!busy));
        if (busy) begin
          k++;
          n = acc_cycles(cur);
          if (k == 1) expc = 3'b100;
          else if (k <= n + 1) expc = 3'b110;
          else expc = 3'b001;
          chk("ctrl", 64'({bus.psel, bus.penable, bus.rsp_valid}), 64'(expc));
          if (k <= n + 1) begin
            expw = cur.write ? cur.wdata : {DW{1'b0}};
            chk("apb_bus", 64'({bus.pwrite, bus.paddr, bus.pwdata}), 64'({cur.write, cur.addr, expw}));
          end else begin
            chk("rsp", 64'({bus.rsp_rdata, bus.rsp_err, bus.rsp_timeout}), 64'(model_rsp(cur)));
          end
          if (bus.rsp_valid && bus.rsp_ready) busy = 1'b0;
        end else begin
          chk("idle_ctrl", 64'({bus.psel, bus.penable, bus.rsp_valid}), 64'(0));
        end
        if (!busy && bus.req_valid && bus.req_ready) begin
          if (exp_q.size() == 0) begin
            errors++; checks++;
            $display("FAIL accept: got accept expected no pending command at %0t", $time);
          end else begin
            cur = exp_q.pop_front();
            busy = 1'b1;
            k = 0;
          end
        end
      end
    end
  end

  task automatic issue(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input int waits, input bit err, input logic [DW-1:0] rd);
    txn_t t;
    bit   acc = 1'b0;
    t.write = w; t.addr = a; t.wdata = d; t.waits = waits; t.slverr = err; t.prdata = rd;
    exp_q.push_back(t);
    plan_q.push_back(t);
    bus.req_valid = 1'b1; bus.req_write = w; bus.req_addr = a; bus.req_wdata = d;
    for (int i = 0; i < 400; i++) begin
      @(negedge pclk);
      if (bus.req_ready) begin acc = 1'b1; break; end
    end
    if (!acc) begin
      errors++; checks++;
      $display("FAIL accept_wait: got no accept expected accept within 400 cycles");
    end
    @(posedge pclk); #1;
    bus.req_valid = 1'b0;
    bus.req_write = 1'($urandom_range(0, 1));
    bus.req_addr  = AW'($urandom);
    bus.req_wdata = DW'($urandom);
  endtask

  function automatic logic [63:0] out_vec();
    return 64'({bus.psel, bus.penable, bus.pwrite, bus.paddr, bus.pwdata, bus.rsp_valid,
                bus.rsp_rdata, bus.rsp_err, bus.rsp_timeout, bus.req_ready});
  endfunction

  initial begin
    bit drained = 1'b0;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    repeat (3) @(posedge pclk);
    bus.req_valid = 1'b1;
    @(negedge pclk);
    chk("reset_outputs", out_vec(), 64'(0));
    @(posedge pclk); #1;
    bus.req_valid = 1'b0;
    prst = 1'b0;

    issue(1'b1, 32'd3, 8'hA5, 0, 1'b0, 8'h77);
    issue(1'b0, 32'd3, 8'h11, 3, 1'b0, 8'hA5);
    issue(1'b0, 32'd20, 8'h22, 0, 1'b1, 8'h3C);
    issue(1'b0, 32'h1234, 8'h33, 100, 1'b0, 8'h44);
    issue(1'b0, 32'h5678, 8'h55, TO - 1, 1'b0, 8'h66);
    issue(1'b1, 32'h9ABC, 8'h5A, TO - 1, 1'b1, 8'h99);

    bp_len = 5;
    issue(1'b1, 32'hBEEF, 8'hC3, 1, 1'b0, 8'h00);
    issue(1'b0, 32'hCAFE, 8'h00, 0, 1'b0, 8'h5E);
    for (int i = 0; i < 60 && busy; i++) @(negedge pclk);
    bp_len = -1;

    // Reset during a waited read: transfer must vanish without a response
    @(posedge pclk); #1;
    issue(1'b0, 32'h55, 8'h00, 100, 1'b0, 8'hEE);
    for (int i = 0; i < 50 && !(bus.psel && bus.penable); i++) @(negedge pclk);
    repeat (3) @(negedge pclk);
    @(posedge pclk); #1;
    prst = 1'b1;
    @(posedge pclk);
    @(negedge pclk);
    chk("mid_reset_outputs", out_vec(), 64'(0));
    @(posedge pclk); #1;
    prst = 1'b0;
    issue(1'b1, 32'h77, 8'h3D, 2, 1'b0, 8'h00);

    for (int i = 0; i < 40; i++) begin
      int r, w;
      r = int'($urandom_range(0, 9));
      w = (r < 6) ? int'($urandom_range(0, 3)) : (r < 8) ? int'($urandom_range(13, 17))
                                                        : int'($urandom_range(18, 40));
      issue(1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom), w,
            ($urandom_range(0, 4) == 0), DW'($urandom));
      repeat ($urandom_range(0, 3)) begin @(posedge pclk); #1; end
    end

    for (int i = 0; i < 500; i++) begin
      @(negedge pclk);
      if (!busy && exp_q.size() == 0) begin drained = 1'b1; break; end
    end
    chk("drain", 64'(drained), 64'(1));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
